echo_core_arbiter: RTL and testbench
====================================

// Module: echo_core_arbiter
// PURPOSE
//  Shares one ECHO hash core (load/fetch/busy/ack/odata interface) between two host requesters.
//  Grants the core to one requester at a time, round-robin, and muxes that requester's load/fetch/idata onto the core.
//  Holds the grant until the owner releases it, then waits for the core to finish before re-arbitrating.
//  Revokes a grant that sits idle for TIMEOUT cycles.
//  Sits between the host-side bus adapters and the core interface.
// PARAMETERS
//  DW       16    host/core data word width (bits)
//  TIMEOUT  1024  idle-grant cycles before forced release (>=2)
// PORTS
//  clk          in   1     system clock; single clock domain
//  rst          in   1     synchronous, active-high reset
//  req          in   2     per-requester level request for the core
//  rel          in   2     per-requester release pulse; honoured only from the current owner
//  m_load       in   2     per-requester load strobe (passed to core_load when owner)
//  m_fetch      in   2     per-requester fetch strobe (passed to core_fetch when owner)
//  m_idata      in   2*DW  per-requester data; [DW-1:0]=req0, [2*DW-1:DW]=req1
//  gnt          out  2     one-hot-or-zero grant, registered
//  core_load    out  1     load to core = m_load[owner] & gnt[owner]
//  core_fetch   out  1     fetch to core = m_fetch[owner] & gnt[owner]
//  core_idata   out  DW    m_idata slice of owner; zero when no grant
//  core_busy    in   1     core processing a block
//  core_ack     in   1     core acknowledge
//  core_odata   in   DW    core output word (hash fragment)
//  s_ack        out  2     core_ack routed to owner only
//  s_odata      out  DW    core_odata, broadcast (qualify with s_ack/gnt)
//  err_timeout  out  1     one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, err_timeout=0, idle_cnt=0, last=1 (req0 wins the first arbitration).
//    All core_* outputs and s_ack are 0.
//  FSM states:
//   IDLE:  If any req: owner = !last when req[!last], else the single requester.
//     Set gnt[owner] next edge -> GRANT.
//     Latency: req seen at edge t gives gnt high after edge t+1.
//   GRANT:
//     Owner load/fetch/idata are routed combinationally from the registered gnt.
//     Non-owner strobes are ignored, never forwarded.
//     rel[owner]=1 -> gnt<=0, last<=owner, -> DRAIN. rel from the non-owner is ignored.
//     Owner dropping req without rel does not end the grant; only rel or timeout ends it.
//     Timeout: idle_cnt increments each cycle with m_load[owner]=m_fetch[owner]=core_busy=0.
//       It clears on any such activity.
//       At idle_cnt==TIMEOUT-1: gnt<=0, last<=owner, err_timeout pulses 1 cycle -> DRAIN.
//     rel and timeout in the same cycle: treat as rel; no err_timeout.
//   DRAIN: gnt=0 and all core strokes are 0. -> IDLE at the first edge with core_busy=0.
//     The minimum stay is 1 cycle.
//  Minimum regrant gap: rel at edge t, DRAIN t+1, IDLE t+2, new gnt after t+3.
//    No two grants are ever adjacent.
//  Both req high in IDLE: the requester not served last wins. Alternation is strict under continuous contention.
//  idle_cnt is sized clog2(TIMEOUT). It saturates at TIMEOUT-1 and never wraps.
//  rst mid-GRANT or mid-DRAIN: gnt drops on the same edge, even if core_busy=1.
//    The core's own reset covers it.
//  gnt is never 2'b11. Assert this in the bench.
// TESTING
//  1. req=01 after reset -> gnt=01 two edges later; m_load[0] pulse -> core_load=1 in the same cycle;
//     m_load[1] -> core_load stays 0.
//  2. req=11 continuously, owner rel after 5 cycles each -> grant order 01,10,01,10; gap of 2 gnt=00 cycles between grants.
//  3. rel[0] while core_busy=1 for 20 cycles -> gnt=00 held in DRAIN until core_busy falls;
//     the next grant follows 2 edges later.
//  4. TIMEOUT=8, owner idle -> gnt drops after 8 idle cycles, err_timeout=1 for exactly 1 cycle;
//     rel on the last idle cycle -> no err_timeout.
//  5. core_ack=1, core_odata=16'hA5C3 during gnt=10 -> s_ack=10, s_odata=16'hA5C3; s_ack[0]=0.
//  6. rst=1 mid-GRANT with core_busy=1 -> gnt, core_load, core_fetch, core_idata = 0 next edge;
//     after release, req=11 -> req0 granted.

Source files
------------

// File: rtl/echo_core_arbiter.sv
// Two-requester round-robin arbiter that shares one ECHO hash core.
// Holds a grant until release or idle timeout, then drains the core before re-arbitrating.
module echo_core_arbiter #(
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [1:0]      rel,
    input  logic [1:0]      m_load,
    input  logic [1:0]      m_fetch,
    input  logic [2*DW-1:0] m_idata,
    output logic [1:0]      gnt,
    output logic            core_load,
    output logic            core_fetch,
    output logic [DW-1:0]   core_idata,
    input  logic            core_busy,
    input  logic            core_ack,
    input  logic [DW-1:0]   core_odata,
    output logic [1:0]      s_ack,
    output logic [DW-1:0]   s_odata,
    output logic            err_timeout
);

    localparam int unsigned   CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic owner;
    logic other;
    logic sel;
    logic owner_active;

    // The owner index is derived from the registered one-hot grant.
    assign owner        = gnt_q[1];
    assign other        = ~last_q;
    assign sel          = req[other] ? other : last_q;
    assign owner_active = m_load[owner] | m_fetch[owner] | core_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Release wins over a coincident timeout, so no error pulse then.
                if (rel[owner]) begin
                    gnt_d   = '0;
                    last_d  = owner;
                    state_d = S_DRAIN;
                end else if (owner_active) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    gnt_d   = '0;
                    last_d  = owner;
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = '0;
                if (!core_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt         = gnt_q;
    assign err_timeout = err_q;
    assign core_load   = |(m_load & gnt_q);
    assign core_fetch  = |(m_fetch & gnt_q);
    assign core_idata  = ({DW{gnt_q[0]}} & m_idata[DW-1:0])
                       | ({DW{gnt_q[1]}} & m_idata[2*DW-1:DW]);
    assign s_ack       = gnt_q & {2{core_ack}};
    assign s_odata     = core_odata;

endmodule

// File: tb/tb_echo_core_arbiter.sv
// Bench for echo_core_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural owner/drain/idle-run model.
module tb_echo_core_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned T  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req, rel, m_load, m_fetch;
    logic [2*DW-1:0] m_idata;
    logic [1:0]      gnt;
    logic            core_load, core_fetch;
    logic [DW-1:0]   core_idata;
    logic            core_busy, core_ack;
    logic [DW-1:0]   core_odata;
    logic [1:0]      s_ack;
    logic [DW-1:0]   s_odata;
    logic            err_timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the core, whether it is draining, idle-run length.
    int m_owner = -1;
    bit m_drain = 0;
    int m_last  = 1;
    int m_idle  = 0;
    bit m_err   = 0;

    echo_core_arbiter #(.DW(DW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .m_load(m_load), .m_fetch(m_fetch),
        .m_idata(m_idata), .gnt(gnt), .core_load(core_load), .core_fetch(core_fetch),
        .core_idata(core_idata), .core_busy(core_busy), .core_ack(core_ack),
        .core_odata(core_odata), .s_ack(s_ack), .s_odata(s_odata), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_gnt();
        return (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    endfunction

    task automatic model_edge();
        int  other;
        bit  act;
        if (rst) begin
            m_owner = -1; m_drain = 0; m_last = 1; m_idle = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_drain) begin
                if (!core_busy) m_drain = 0;
            end else if (m_owner < 0) begin
                if (req != 2'b00) begin
                    other   = 1 - m_last;
                    m_owner = req[other] ? other : (req[0] ? 0 : 1);
                    m_idle  = 0;
                end
            end else begin
                act = m_load[m_owner] | m_fetch[m_owner] | core_busy;
                if (rel[m_owner]) begin
                    m_last = m_owner; m_owner = -1; m_drain = 1;
                end else if (act) begin
                    m_idle = 0;
                end else if (m_idle == T - 1) begin
                    m_last = m_owner; m_owner = -1; m_drain = 1; m_err = 1;
                end else begin
                    m_idle++;
                end
            end
        end
    endtask

    // Check routed outputs against the model, clock once, then check registered outputs.
    task automatic step();
        logic [DW-1:0] eid;
        #1;
        eid = (m_owner == 0) ? m_idata[DW-1:0] : (m_owner == 1) ? m_idata[2*DW-1:DW] : '0;
        check("core_load", core_load, (m_owner >= 0) ? m_load[m_owner] : 1'b0);
        check("core_fetch", core_fetch, (m_owner >= 0) ? m_fetch[m_owner] : 1'b0);
        check("core_idata", core_idata, eid);
        check("s_ack", s_ack, core_ack ? exp_gnt() : 2'b00);
        check("s_odata", s_odata, core_odata);
        @(posedge clk);
        model_edge();
        #1;
        check("gnt", gnt, exp_gnt());
        check("err_timeout", err_timeout, m_err);
        check("gnt_not_11", gnt == 2'b11, 1'b0);
    endtask

    initial begin
        int n;
        int gap;
        rst = 1'b1; req = '0; rel = '0; m_load = '0; m_fetch = '0; m_idata = '0;
        core_busy = 1'b0; core_ack = 1'b0; core_odata = '0;
        @(posedge clk); #1;
        step(); step();
        check("rst_gnt", gnt, 2'b00);
        check("rst_err", err_timeout, 1'b0);
        check("rst_core_load", core_load, 1'b0);
        rst = 1'b0;
        step();

        // Single requester; owner strobes pass, non-owner strobes do not.
        req = 2'b01;
        step();
        check("t1_gnt", gnt, 2'b01);
        m_load = 2'b01; #1;
        check("t1_load_owner", core_load, 1'b1);
        step();
        m_load = 2'b10; #1;
        check("t1_load_nonowner", core_load, 1'b0);
        step();
        m_load = '0; rel = 2'b10;
        step();
        check("t1_rel_nonowner", gnt, 2'b01);
        rel = 2'b01; step(); rel = '0; step(); step();

        // Continuous contention: strict alternation with a two-cycle gap.
        rst = 1'b1; req = '0; step(); rst = 1'b0;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            gap = 0;
            while (gnt == 2'b00 && gap < 20) begin step(); gap++; end
            if (g != 0) check("t2_gap", gap, 2);
            check("t2_order", gnt, (g % 2 == 0) ? 2'b01 : 2'b10);
            repeat (5) step();
            rel = gnt; step(); rel = '0;
        end

        // Release while the core is busy: stay drained until busy falls.
        gap = 0;
        while (gnt == 2'b00 && gap < 20) begin step(); gap++; end
        check("t3_gnt", gnt, 2'b01);
        core_busy = 1'b1;
        step(); step();
        rel = gnt; step(); rel = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t3_drain", gnt, 2'b00);
        end
        core_busy = 1'b0;
        step();
        check("t3_idle", gnt, 2'b00);
        step();
        check("t3_regrant", gnt, 2'b10);

        // Idle timeout after T cycles, error pulse lasts one cycle.
        n = 1;
        while (gnt != 2'b00 && n < 30) begin
            step();
            if (gnt != 2'b00) n++;
        end
        check("t4_idle_len", n, T);
        check("t4_err", err_timeout, 1'b1);
        step();
        check("t4_err_pulse", err_timeout, 1'b0);
        gap = 0;
        while (gnt == 2'b00 && gap < 20) begin step(); gap++; end
        check("t4_gnt2", gnt, 2'b01);
        repeat (T - 1) step();
        rel = gnt; step(); rel = '0;
        check("t4_rel_gnt", gnt, 2'b00);
        check("t4_rel_no_err", err_timeout, 1'b0);

        // Acknowledge routing to the current owner.
        gap = 0;
        while (gnt == 2'b00 && gap < 20) begin step(); gap++; end
        check("t5_gnt", gnt, 2'b10);
        core_ack = 1'b1; core_odata = 16'hA5C3; #1;
        check("t5_s_ack", s_ack, 2'b10);
        check("t5_s_odata", s_odata, 16'hA5C3);
        step();
        core_ack = 1'b0;

        // Reset in the middle of a busy grant.
        core_busy = 1'b1; m_load = 2'b11; m_fetch = 2'b11; m_idata = 32'h1234_5678;
        rst = 1'b1;
        step();
        check("t6_gnt", gnt, 2'b00);
        check("t6_load", core_load, 1'b0);
        check("t6_fetch", core_fetch, 1'b0);
        check("t6_idata", core_idata, 16'h0000);
        rst = 1'b0; core_busy = 1'b0; m_load = '0; m_fetch = '0; req = 2'b11;
        step();
        check("t6_regrant", gnt, 2'b01);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req        = 2'($urandom);
            rel        = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            m_load     = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            m_fetch    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            core_busy  = ($urandom_range(0, 3) == 0);
            core_ack   = 1'($urandom);
            m_idata    = 32'($urandom);
            core_odata = 16'($urandom);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
